// File: rtl/axil_arb2_tiny.sv
// axil_arb2_tiny: shares one AXI-Lite peripheral port between two masters.
// One transaction in flight at a time; round-robin or fixed-priority grant.
module axil_arb2_tiny #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RR     = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // master 0
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [2:0]          m0_awprot,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    input  logic                m0_arvalid,
    output logic                m0_arready,
    input  logic [ADDR_W-1:0]   m0_araddr,
    input  logic [2:0]          m0_arprot,
    output logic                m0_rvalid,
    input  logic                m0_rready,
    output logic [DATA_W-1:0]   m0_rdata,
    // master 1
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [2:0]          m1_awprot,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    input  logic                m1_arvalid,
    output logic                m1_arready,
    input  logic [ADDR_W-1:0]   m1_araddr,
    input  logic [2:0]          m1_arprot,
    output logic                m1_rvalid,
    input  logic                m1_rready,
    output logic [DATA_W-1:0]   m1_rdata,
    // peripheral port
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [2:0]          s_awprot,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_bvalid,
    output logic                s_bready,
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [2:0]          s_arprot,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic                gnt_o,
    output logic                busy_o
);

    typedef enum logic [2:0] {StIdle, StWaddr, StWresp, StRaddr, StRdata} state_e;

    state_e r_state, w_state_d;
    logic   r_gnt, w_gnt_d;
    logic   r_last, w_last_d;
    logic   r_aw_done, w_aw_done_d;
    logic   r_w_done, w_w_done_d;

    logic [1:0] w_wreq, w_req;
    logic       w_winner;
    logic       w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;
    logic       w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
    logic       w_aw_now, w_w_now;

    assign w_wreq = {m1_awvalid & m1_wvalid, m0_awvalid & m0_wvalid};
    assign w_req  = w_wreq | {m1_arvalid, m0_arvalid};

    // Contention: round-robin favours whoever was not served last.
    assign w_winner = (w_req == 2'b11) ? ((RR != 0) ? ~r_last : 1'b0) : w_req[1];

    assign w_g_awvalid = r_gnt ? m1_awvalid : m0_awvalid;
    assign w_g_wvalid  = r_gnt ? m1_wvalid  : m0_wvalid;
    assign w_g_bready  = r_gnt ? m1_bready  : m0_bready;
    assign w_g_arvalid = r_gnt ? m1_arvalid : m0_arvalid;
    assign w_g_rready  = r_gnt ? m1_rready  : m0_rready;

    assign s_awaddr = r_gnt ? m1_awaddr : m0_awaddr;
    assign s_awprot = r_gnt ? m1_awprot : m0_awprot;
    assign s_wdata  = r_gnt ? m1_wdata  : m0_wdata;
    assign s_wstrb  = r_gnt ? m1_wstrb  : m0_wstrb;
    assign s_araddr = r_gnt ? m1_araddr : m0_araddr;
    assign s_arprot = r_gnt ? m1_arprot : m0_arprot;

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    assign busy_o = (r_state != StIdle);
    assign gnt_o  = busy_o & r_gnt;

    always_comb begin
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        w_arready = 1'b0;
        w_rvalid  = 1'b0;
        case (r_state)
            StWaddr: begin
                s_awvalid = w_g_awvalid & ~r_aw_done;
                s_wvalid  = w_g_wvalid & ~r_w_done;
                w_awready = s_awready & ~r_aw_done;
                w_wready  = s_wready & ~r_w_done;
            end
            StWresp: begin
                w_bvalid = s_bvalid;
                s_bready = w_g_bready;
            end
            StRaddr: begin
                s_arvalid = w_g_arvalid;
                w_arready = s_arready;
            end
            StRdata: begin
                w_rvalid = s_rvalid;
                s_rready = w_g_rready;
            end
            default: ;
        endcase
    end

    assign m0_awready = w_awready & ~r_gnt;
    assign m0_wready  = w_wready  & ~r_gnt;
    assign m0_bvalid  = w_bvalid  & ~r_gnt;
    assign m0_arready = w_arready & ~r_gnt;
    assign m0_rvalid  = w_rvalid  & ~r_gnt;
    assign m1_awready = w_awready & r_gnt;
    assign m1_wready  = w_wready  & r_gnt;
    assign m1_bvalid  = w_bvalid  & r_gnt;
    assign m1_arready = w_arready & r_gnt;
    assign m1_rvalid  = w_rvalid  & r_gnt;

    assign w_aw_now = r_aw_done | (s_awvalid & s_awready);
    assign w_w_now  = r_w_done  | (s_wvalid & s_wready);

    always_comb begin
        w_state_d   = r_state;
        w_gnt_d     = r_gnt;
        w_last_d    = r_last;
        w_aw_done_d = r_aw_done;
        w_w_done_d  = r_w_done;
        case (r_state)
            StIdle: begin
                if (w_req != 2'b00) begin
                    w_gnt_d   = w_winner;
                    // A master asking for both gets its write first.
                    w_state_d = w_wreq[w_winner] ? StWaddr : StRaddr;
                end
            end
            StWaddr: begin
                if (w_aw_now && w_w_now) begin
                    w_state_d   = StWresp;
                    w_aw_done_d = 1'b0;
                    w_w_done_d  = 1'b0;
                end else begin
                    w_aw_done_d = w_aw_now;
                    w_w_done_d  = w_w_now;
                end
            end
            StWresp: begin
                if (s_bvalid && s_bready) begin
                    w_state_d = StIdle;
                    w_last_d  = r_gnt;
                end
            end
            StRaddr: begin
                if (s_arvalid && s_arready) w_state_d = StRdata;
            end
            StRdata: begin
                if (s_rvalid && s_rready) begin
                    w_state_d = StIdle;
                    w_last_d  = r_gnt;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_gnt     <= 1'b0;
            r_last    <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_gnt     <= w_gnt_d;
            r_last    <= w_last_d;
            r_aw_done <= w_aw_done_d;
            r_w_done  <= w_w_done_d;
        end
    end

endmodule

// File: tb/tb_axil_arb2_tiny.sv
// Bench for axil_arb2_tiny: random two-master traffic with a queue scoreboard,
// plus directed reset, round-robin and fixed-priority checks.
module tb_axil_arb2_tiny;

    localparam int NTXN = 30;
    localparam logic [31:0] A0 = 32'h0300_4000;
    localparam logic [31:0] A1 = 32'h0300_5000;

    typedef struct packed {
        logic        is_wr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [1:0]  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic [31:0] m_awaddr [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_araddr [2];
    logic [2:0]  m_awprot [2];
    logic [2:0]  m_arprot [2];
    logic [3:0]  m_wstrb [2];
    logic [1:0]  m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic        gnt, busy;

    int total = 0;
    int bad = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic mon_en = 1'b1;

    axil_arb2_tiny #(.ADDR_W(32), .DATA_W(32), .RR(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]), .m0_awaddr(m_awaddr[0]),
        .m0_awprot(m_awprot[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
        .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_bvalid(m_bvalid[0]),
        .m0_bready(m_bready[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
        .m0_araddr(m_araddr[0]), .m0_arprot(m_arprot[0]), .m0_rvalid(m_rvalid[0]),
        .m0_rready(m_rready[0]), .m0_rdata(m0_rdata),
        .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]), .m1_awaddr(m_awaddr[1]),
        .m1_awprot(m_awprot[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
        .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_bvalid(m_bvalid[1]),
        .m1_bready(m_bready[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
        .m1_araddr(m_araddr[1]), .m1_arprot(m_arprot[1]), .m1_rvalid(m_rvalid[1]),
        .m1_rready(m_rready[1]), .m1_rdata(m1_rdata),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_awprot(s_awprot), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_arprot(s_arprot), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .gnt_o(gnt), .busy_o(busy)
    );

    // Fixed-priority instance: both masters read continuously, slave always ready.
    logic        fp_rst;
    logic        fp_m0_awready, fp_m0_wready, fp_m0_bvalid, fp_m0_arready, fp_m0_rvalid;
    logic        fp_m1_awready, fp_m1_wready, fp_m1_bvalid, fp_m1_arready, fp_m1_rvalid;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_awaddr, fp_s_wdata, fp_s_araddr;
    logic [2:0]  fp_s_awprot, fp_s_arprot;
    logic [3:0]  fp_s_wstrb;
    logic        fp_s_awvalid, fp_s_wvalid, fp_s_bready, fp_s_arvalid, fp_s_rready;
    logic        fp_gnt, fp_busy;
    logic        fp_done = 1'b0;

    axil_arb2_tiny #(.ADDR_W(32), .DATA_W(32), .RR(0)) dut_fp (
        .clk_i(clk), .rst_i(fp_rst),
        .m0_awvalid(1'b0), .m0_awready(fp_m0_awready), .m0_awaddr(32'h0),
        .m0_awprot(3'd0), .m0_wvalid(1'b0), .m0_wready(fp_m0_wready), .m0_wdata(32'h0),
        .m0_wstrb(4'h0), .m0_bvalid(fp_m0_bvalid), .m0_bready(1'b1),
        .m0_arvalid(1'b1), .m0_arready(fp_m0_arready), .m0_araddr(A0), .m0_arprot(3'd0),
        .m0_rvalid(fp_m0_rvalid), .m0_rready(1'b1), .m0_rdata(fp_m0_rdata),
        .m1_awvalid(1'b0), .m1_awready(fp_m1_awready), .m1_awaddr(32'h0),
        .m1_awprot(3'd0), .m1_wvalid(1'b0), .m1_wready(fp_m1_wready), .m1_wdata(32'h0),
        .m1_wstrb(4'h0), .m1_bvalid(fp_m1_bvalid), .m1_bready(1'b1),
        .m1_arvalid(1'b1), .m1_arready(fp_m1_arready), .m1_araddr(A1), .m1_arprot(3'd0),
        .m1_rvalid(fp_m1_rvalid), .m1_rready(1'b1), .m1_rdata(fp_m1_rdata),
        .s_awvalid(fp_s_awvalid), .s_awready(1'b1), .s_awaddr(fp_s_awaddr),
        .s_awprot(fp_s_awprot), .s_wvalid(fp_s_wvalid), .s_wready(1'b1),
        .s_wdata(fp_s_wdata), .s_wstrb(fp_s_wstrb), .s_bvalid(1'b0), .s_bready(fp_s_bready),
        .s_arvalid(fp_s_arvalid), .s_arready(1'b1), .s_araddr(fp_s_araddr),
        .s_arprot(fp_s_arprot), .s_rvalid(1'b1), .s_rready(fp_s_rready),
        .s_rdata(32'h1234_5678), .gnt_o(fp_gnt), .busy_o(fp_busy)
    );

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop(input logic n, output exp_t e, output logic ok);
        ok = 1'b0;
        e  = '0;
        if (!n && q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
        if (n && q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
    endtask

    // Scoreboard / reference: arbitration rule, payload routing and response order.
    logic       mdl_busy, mdl_gnt, mdl_wr, mdl_last;
    logic [15:0] aw_n, w_n;
    initial begin
        logic [1:0] wreq, req;
        logic g, ng, ok;
        exp_t e;
        mdl_busy = 1'b0; mdl_last = 1'b1; mdl_gnt = 1'b0; mdl_wr = 1'b0;
        aw_n = '0; w_n = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mdl_busy = 1'b0;
                mdl_last = 1'b1;
            end else if (mon_en) begin
                if (!mdl_busy) begin
                    chk("idle_outputs", {15'd0, busy, gnt, s_awvalid, s_wvalid, s_arvalid,
                        s_bready, s_rready, m_awready, m_wready, m_bvalid, m_arready,
                        m_rvalid}, 32'd0);
                    wreq = m_awvalid & m_wvalid;
                    req  = wreq | m_arvalid;
                    if (req != 2'b00) begin
                        mdl_gnt  = (req == 2'b11) ? ~mdl_last : req[1];
                        mdl_wr   = wreq[mdl_gnt];
                        mdl_busy = 1'b1;
                        aw_n = '0; w_n = '0;
                    end
                end else begin
                    g = mdl_gnt; ng = ~mdl_gnt;
                    chk("grant", {30'd0, busy, gnt}, {30'd0, 1'b1, g});
                    chk("other_quiet", {27'd0, m_awready[ng], m_wready[ng], m_bvalid[ng],
                        m_arready[ng], m_rvalid[ng]}, 32'd0);
                    if (s_awvalid && s_awready) begin
                        aw_n++;
                        chk("aw_kind", {31'd0, mdl_wr}, 32'd1);
                        chk("s_awaddr", s_awaddr, m_awaddr[g]);
                        chk("s_awprot", {29'd0, s_awprot}, {29'd0, m_awprot[g]});
                    end
                    if (s_wvalid && s_wready) begin
                        w_n++;
                        chk("s_wdata", s_wdata, m_wdata[g]);
                        chk("s_wstrb", {28'd0, s_wstrb}, {28'd0, m_wstrb[g]});
                    end
                    if (s_arvalid && s_arready) begin
                        chk("ar_kind", {31'd0, mdl_wr}, 32'd0);
                        chk("s_araddr", s_araddr, m_araddr[g]);
                        chk("s_arprot", {29'd0, s_arprot}, {29'd0, m_arprot[g]});
                    end
                    if (m_bvalid[g] && m_bready[g]) begin
                        pop(g, e, ok);
                        chk("b_expected", {31'd0, ok}, 32'd1);
                        chk("b_kind", {31'd0, e.is_wr}, 32'd1);
                        chk("aw_w_once", {aw_n, w_n}, {16'd1, 16'd1});
                        mdl_busy = 1'b0;
                        mdl_last = g;
                    end
                    if (m_rvalid[g] && m_rready[g]) begin
                        pop(g, e, ok);
                        chk("r_expected", {31'd0, ok}, 32'd1);
                        chk("r_kind", {31'd0, e.is_wr}, 32'd0);
                        chk("rdata", g ? m1_rdata : m0_rdata, e.data);
                        mdl_busy = 1'b0;
                        mdl_last = g;
                    end
                end
            end
        end
    end

    // Fixed priority: master 0 wins every transaction, master 1 never served.
    initial begin
        int cnt;
        cnt = 0;
        fp_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 fp_rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("fp_m1_arready", {31'd0, fp_m1_arready}, 32'd0);
            if (fp_busy) chk("fp_gnt", {31'd0, fp_gnt}, 32'd0);
            if (fp_m0_rvalid) begin
                cnt++;
                chk("fp_rdata", fp_m0_rdata, 32'h1234_5678);
            end
        end
        chk("fp_count", cnt, 32'd20);
        fp_done = 1'b1;
    end

    // Stimulus: random masters and a random-latency slave.
    logic [1:0] pa, pw, par, wb, wr;
    logic [1:0] h_aw, h_w, h_ar, h_b, h_r;
    logic       h_saw, h_sw, h_sar, h_sb, h_sr;
    logic [31:0] h_sar_addr, r_addr_l;
    logic       s_aw_got, s_w_got;
    int         b_dly, r_dly, k;
    int         nrem [2];

    initial begin
        int cyc, kind;
        logic all_done;
        exp_t e;
        rst = 1'b1;
        m_awvalid = '0; m_wvalid = '0; m_arvalid = '0; m_bready = '0; m_rready = '0;
        for (int n = 0; n < 2; n++) begin
            m_awaddr[n] = '0; m_wdata[n] = '0; m_araddr[n] = '0;
            m_awprot[n] = '0; m_arprot[n] = '0; m_wstrb[n] = '0;
            nrem[n] = NTXN;
        end
        s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
        s_bvalid = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        pa = '0; pw = '0; par = '0; wb = '0; wr = '0;
        h_aw = '0; h_w = '0; h_ar = '0; h_b = '0; h_r = '0;
        h_saw = 0; h_sw = 0; h_sar = 0; h_sb = 0; h_sr = 0; h_sar_addr = '0;
        s_aw_got = 0; s_w_got = 0; b_dly = -1; r_dly = -1; r_addr_l = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        all_done = 1'b0;
        for (cyc = 0; cyc < 20000 && !all_done; cyc++) begin
            @(posedge clk);
            #1;
            pa &= ~h_aw; pw &= ~h_w; par &= ~h_ar; wb &= ~h_b; wr &= ~h_r;
            if (h_saw) s_aw_got = 1'b1;
            if (h_sw) s_w_got = 1'b1;
            if (h_sb) s_bvalid = 1'b0;
            if (h_sr) s_rvalid = 1'b0;
            if (s_aw_got && s_w_got && b_dly < 0 && !s_bvalid) b_dly = $urandom_range(0, 3);
            if (b_dly == 0) begin
                s_bvalid = 1'b1; b_dly = -1; s_aw_got = 1'b0; s_w_got = 1'b0;
            end else if (b_dly > 0) b_dly--;
            if (h_sar) begin r_addr_l = h_sar_addr; r_dly = $urandom_range(0, 3); end
            if (r_dly == 0) begin
                s_rvalid = 1'b1; s_rdata = rd_val(r_addr_l); r_dly = -1;
            end else if (r_dly > 0) r_dly--;
            s_awready = ($urandom % 3) != 0;
            s_wready  = ($urandom % 3) != 0;
            s_arready = ($urandom % 3) != 0;
            for (int n = 0; n < 2; n++) begin
                if (!(pa[n] | pw[n] | par[n] | wb[n] | wr[n]) && nrem[n] > 0 && $urandom % 2 == 1) begin
                    kind = $urandom % 4;
                    nrem[n]--;
                    if (kind >= 2) begin
                        m_awaddr[n] = 32'h0300_0000 | ($urandom & 32'h0000_FFFC);
                        m_awprot[n] = 3'($urandom);
                        m_wdata[n]  = $urandom;
                        m_wstrb[n]  = 4'($urandom);
                        pa[n] = 1'b1; pw[n] = 1'b1; wb[n] = 1'b1;
                        e = '{is_wr: 1'b1, data: m_wdata[n]};
                        if (n == 0) q0.push_back(e); else q1.push_back(e);
                    end
                    if (kind != 2) begin
                        m_araddr[n] = 32'h0300_0000 | ($urandom & 32'h0000_FFFC);
                        m_arprot[n] = 3'($urandom);
                        par[n] = 1'b1; wr[n] = 1'b1;
                        e = '{is_wr: 1'b0, data: rd_val(m_araddr[n])};
                        if (n == 0) q0.push_back(e); else q1.push_back(e);
                    end
                end
                m_bready[n] = ($urandom % 4) != 0;
                m_rready[n] = ($urandom % 4) != 0;
            end
            m_awvalid = pa; m_wvalid = pw; m_arvalid = par;
            #2;
            h_aw = m_awvalid & m_awready; h_w = m_wvalid & m_wready;
            h_ar = m_arvalid & m_arready; h_b = m_bvalid & m_bready; h_r = m_rvalid & m_rready;
            h_saw = s_awvalid & s_awready; h_sw = s_wvalid & s_wready;
            h_sar = s_arvalid & s_arready; h_sar_addr = s_araddr;
            h_sb = s_bvalid & s_bready; h_sr = s_rvalid & s_rready;
            all_done = (nrem[0] == 0) && (nrem[1] == 0) && ((pa | pw | par | wb | wr) == 2'b00);
        end
        chk("random_done", {31'd0, all_done}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("queues_empty", q0.size() + q1.size(), 32'd0);
        chk("model_idle", {31'd0, mdl_busy}, 32'd0);

        // Reset while waiting in the read-data phase.
        mon_en = 1'b0;
        m_bready = 2'b11; m_rready = 2'b11;
        s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b1; s_bvalid = 1'b0; s_rvalid = 1'b0;
        m_araddr[0] = A0; m_araddr[1] = A1;
        m_arvalid = 2'b01;
        repeat (2) @(posedge clk);
        #1 m_arvalid = 2'b00;
        chk("rdata_phase_busy", {30'd0, busy, gnt}, 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_abandon", {27'd0, busy, gnt, s_awvalid, s_wvalid, s_arvalid}, 32'd0);
        rst = 1'b0;

        // Round robin with both masters reading continuously.
        m_arvalid = 2'b11;
        s_rvalid = 1'b1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 s_rdata = rd_val(s_araddr);
            #1;
            if (s_arvalid && s_arready) begin
                chk("rr_gnt", {31'd0, gnt}, k % 2);
                chk("rr_addr", s_araddr, (k % 2 == 1) ? A1 : A0);
                k++;
            end
            if (m_rvalid[0]) chk("rr_rdata0", m0_rdata, rd_val(A0));
            if (m_rvalid[1]) chk("rr_rdata1", m1_rdata, rd_val(A1));
        end
        chk("rr_count", k, 32'd4);
        m_arvalid = 2'b00;
        s_rvalid = 1'b0;

        wait (fp_done);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
